// File: rtl/fp_div_pkg.sv
// Shared types and width helpers for the sequential sfp divider.
// The bench uses div_num_width too, so both agree on the iteration count.
package fp_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int div_num_width(input int wa, input int qa, input int qb, input int qo);
    return wa + imax(qo + qb - qa, 0);
  endfunction

  function automatic int div_den_width(input int wb, input int qa, input int qb, input int qo);
    return wb + imax(qa - qo - qb, 0);
  endfunction

endpackage

// File: rtl/ufp_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, WN cycles per division.
// last_o flags the final iteration; quo_next_o is the quotient produced by it.
module ufp_div_core #(
  parameter int WN = 12,
  parameter int WD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [WN-1:0] num_i,
  input  logic [WD-1:0] den_i,
  output logic          last_o,
  output logic [WN-1:0] quo_next_o
);

  localparam int CW = $clog2(WN + 1);

  logic [WD-1:0] rem_q, rem_d;
  logic [WN-1:0] quo_q, quo_d;
  logic [WD-1:0] den_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [WD:0]   rem_sh;

  // quo_q starts as the numerator; its MSBs feed the remainder as quotient bits fill in from the LSB.
  // The remainder never reaches den, so a WD-bit modular subtract is exact.
  always_comb begin
    rem_sh = {rem_q, quo_q[WN-1]};
    if (rem_sh >= {1'b0, den_q}) begin
      rem_d = rem_sh[WD-1:0] - den_q;
      quo_d = {quo_q[WN-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WD-1:0];
      quo_d = {quo_q[WN-2:0], 1'b0};
    end
  end

  assign last_o     = busy_q && (cnt_q == '0);
  assign quo_next_o = quo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= num_i;
      den_q  <= den_i;
      cnt_q  <= CW'(WN - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - CW'(1);
      busy_q <= (cnt_q != '0);
    end
  end

endmodule

// File: rtl/sfp_div_seq.sv
// Sequential signed fixed-point divider: out = in1 / in2, truncated toward zero,
// with valid/ready handshakes, saturation or wrap on overflow, and divide-by-zero flag.
module sfp_div_seq
  import fp_div_pkg::*;
#(
  parameter int IW1  = 4,
  parameter int QW1  = 4,
  parameter int IW2  = 4,
  parameter int QW2  = 4,
  parameter int IWO  = 4,
  parameter int QWO  = 4,
  parameter bit CLIP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IW1+QW1-1:0]   in1,
  input  logic [IW2+QW2-1:0]   in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IWO+QWO-1:0]   out,
  output logic                 ovf,
  output logic                 div0
);

  localparam int WA  = IW1 + QW1;
  localparam int WB  = IW2 + QW2;
  localparam int WO  = IWO + QWO;
  localparam int SH  = QWO + QW2 - QW1;
  localparam int SHP = imax(SH, 0);
  localparam int SHN = imax(-SH, 0);
  localparam int WN  = div_num_width(WA, QW1, QW2, QWO);
  localparam int WD  = div_den_width(WB, QW1, QW2, QWO);
  localparam int WC  = imax(WN, WO) + 1;

  localparam logic [WC-1:0] LIM_NEG = WC'(1) << (WO - 1);
  localparam logic [WC-1:0] LIM_POS = LIM_NEG - WC'(1);
  localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO-1){1'b0}}};

  if (WO < 2) begin : g_wo_chk
    $error("sfp_div_seq: output width must be at least 2 bits");
  end

  div_state_e    state_q;
  logic          sign_q, neg1_q, zero1_q, dz_q;
  logic [WA-1:0] a_abs;
  logic [WB-1:0] b_abs;
  logic [WN-1:0] num_w, quo_next;
  logic [WD-1:0] den_w;
  logic          core_start, core_last;
  logic [WC-1:0] q_ext;
  logic [WO-1:0] q_sgn, q_out, z_out;
  logic          q_ovf;

  // Magnitudes read as unsigned, so the most negative input maps to 2^(W-1) without an extra bit.
  assign a_abs = in1[WA-1] ? (WA'(0) - in1) : in1;
  assign b_abs = in2[WB-1] ? (WB'(0) - in2) : in2;
  assign num_w = WN'(a_abs) << SHP;
  assign den_w = WD'(b_abs) << SHN;

  assign core_start = (state_q == IDLE) && in_valid && (in2 != '0);

  ufp_div_core #(.WN(WN), .WD(WD)) u_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (core_start),
    .num_i      (num_w),
    .den_i      (den_w),
    .last_o     (core_last),
    .quo_next_o (quo_next)
  );

  always_comb begin
    q_ext = WC'(quo_next);
    q_sgn = sign_q ? (WO'(0) - WO'(quo_next)) : WO'(quo_next);
    q_ovf = sign_q ? (q_ext > LIM_NEG) : (q_ext > LIM_POS);
    q_out = (q_ovf && CLIP) ? (sign_q ? OUT_MIN : OUT_MAX) : q_sgn;
    z_out = zero1_q ? '0 : (neg1_q ? OUT_MIN : OUT_MAX);
  end

  // A zero divisor still spends one cycle in CALC so its result lands on cycle 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
      sign_q    <= 1'b0;
      neg1_q    <= 1'b0;
      zero1_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in1[WA-1] ^ in2[WB-1];
            neg1_q   <= in1[WA-1];
            zero1_q  <= (in1 == '0);
            dz_q     <= (in2 == '0);
            in_ready <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (dz_q) begin
            out       <= z_out;
            ovf       <= 1'b0;
            div0      <= 1'b1;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else if (core_last) begin
            out       <= q_out;
            ovf       <= q_ovf;
            div0      <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
